pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central stall/flush controller for the five-stage pipeline. Combines load-use hazards, instruction/data memory wait states and a multi-cycle divider into per-stage stall signals. Holds branch and trap redirects while EX is stalled, then releases each one exactly once. Its outputs drive the stall, trap and branch_flag inputs of every pipeline register (if_id, id_ex, ex_mem, mem_wb) and the PC unit.

## Interface
Parameters:
- DIV_CYCLES, 32: cycles the divider occupies EX after start (≥2)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- imem_busy  in  1  instruction fetch not complete
- dmem_busy  in  1  data access in MEM not complete
- id_rs, id_rt  in  5 each  source register numbers of the ID instruction
- id_use_rs, id_use_rt  in  1 each  ID instruction reads rs / rt
- ex_is_load  in  1  EX instruction is a load
- ex_gpr_waddr  in  5  EX destination register
- ex_div_start  in  1  EX holds a DIV/DIVU (level, held while stalled)
- ex_branch  in  1  EX resolved a taken/mispredicted branch
- ex_branch_target  in  32  redirect address for ex_branch
- mem_trap  in  1  MEM raised an exception
- mem_trap_pc  in  32  exception vector
- stall_if, stall_id, stall_ex, stall_mem  out  1 each  per-stage hold
- branch_flag  out  1  one-cycle branch redirect/flush
- trap  out  1  one-cycle trap flush
- redirect_pc  out  32  target for branch_flag/trap
- div_busy  out  1  divider running
- div_done  out  1  quotient/remainder valid this cycle

## Operation
- Divider FSM: IDLE, BUSY, DONE.
  - IDLE→BUSY when ex_div_start & ~dmem_busy; the counter loads DIV_CYCLES-2.
  - BUSY decrements the counter and moves to DONE at 0.
  - DONE asserts div_done for one cycle, then returns to IDLE.
  - A trap output in any state forces IDLE.
  - div_busy = (IDLE & ex_div_start) | BUSY.
- Stall chain:
  - stall_mem = dmem_busy
  - stall_ex = stall_mem | div_busy
  - stall_id = stall_ex | load_use
  - stall_if = stall_id | imem_busy
- load_use = ex_is_load & ex_gpr_waddr≠0 & ((id_use_rs & id_rs==ex_gpr_waddr) | (id_use_rt & id_rt==ex_gpr_waddr)).
- Redirects:
  - A request (mem_trap or ex_branch) seen while stall_ex=1 is latched into a pending slot (kind + pc).
  - A newer branch overwrites a pending branch. A trap overwrites anything.
  - A branch never overwrites a pending trap.
  - When stall_ex=0, output the winner among pending and live requests, with precedence trap > branch. Assert trap or branch_flag for exactly one cycle with redirect_pc, then clear the pending slot.
  - A pending branch is discarded if a trap is output.
  - redirect_pc = 0 when neither trap nor branch_flag is asserted.
- Reset values: FSM=IDLE, counter=0, pending cleared. trap, branch_flag, div_done, redirect_pc are all 0. Stall outputs follow their inputs; div_busy=0 unless ex_div_start is asserted.

## Timing
- All stall outputs are combinational from inputs and FSM state, valid in the same cycle. No registered latency.
- A divide holds EX for exactly DIV_CYCLES cycles: the start cycle, DIV_CYCLES-2 BUSY cycles, and one DONE cycle with stall_ex=0.
- A pending redirect is released in the first cycle stall_ex=0, combinationally.
- dmem_busy during BUSY does not pause the counter.
- When a divide completes while dmem_busy=1, DONE still lasts exactly one cycle.
- Reset mid-divide or with a pending redirect aborts immediately. No redirect is issued after reset.

## Configuration
- CPU_MULTICYCLE_DIV_EN defined: divider FSM and counter as above.
- CPU_MULTICYCLE_DIV_EN undefined:
  - FSM and counter are removed.
  - div_busy=0 and div_done = ex_div_start.
  - ex_div_start never stalls. Divide is treated as single-cycle.
  - DIV_CYCLES is ignored.

## Structure
- Shared package: div_state_t enum (DIV_IDLE, DIV_BUSY, DIV_DONE), redirect_kind_t (RD_NONE, RD_BRANCH, RD_TRAP), and DEFAULT_DIV_CYCLES constant. Existing word_t/regaddr_t/bit_t are reused.
- One natural sub-module: pipe_ctrl_divfsm (FSM + counter, outputs div_busy/div_done, abort input), instantiated under CPU_MULTICYCLE_DIV_EN.

## Test plan
- Load-use: ex_is_load=1, ex_gpr_waddr=5, id_rs=5, id_use_rs=1 → stall_if=stall_id=1, stall_ex=0 for that cycle. With ex_gpr_waddr=0 → no stall.
- Divide, DIV_CYCLES=32: ex_div_start held from cycle 0 → stall_ex=1 for cycles 0–30. div_done=1 and stall_ex=0 in cycle 31. div_busy=0 in cycle 32.
- Branch under stall: dmem_busy=1 for 3 cycles, ex_branch=1 target 0x8000_0040 in cycle 1 → branch_flag=1, redirect_pc=0x8000_0040 for exactly the cycle dmem_busy falls.
- Trap overrides branch: pending branch 0x8000_0040, then mem_trap with pc 0xBFC0_0380 during stall → single trap=1, redirect_pc=0xBFC0_0380. branch_flag is never asserted.
- Trap aborts divide: mem_trap while BUSY at count 10 → trap=1, FSM IDLE next cycle, div_done never asserted.
- Async reset mid-BUSY with a pending branch → outputs return to reset values without a clock edge. No branch_flag after reset release.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Optional multi-cycle divider build is selected with CPU_MULTICYCLE_DIV_EN.
package pipe_ctrl_pkg;

  typedef logic        bit_t;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  regaddr_t;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_t;

  typedef enum logic [1:0] {
    RD_NONE,
    RD_BRANCH,
    RD_TRAP
  } redirect_kind_t;

  typedef struct packed {
    redirect_kind_t kind;
    word_t          pc;
  } redirect_t;

  localparam int DEFAULT_DIV_CYCLES = 32;

endpackage

// File: rtl/pipe_ctrl_divfsm.sv
// Multi-cycle divider occupancy tracker: holds EX for DIV_CYCLES cycles per divide.
// Only instantiated when CPU_MULTICYCLE_DIV_EN is defined.
module pipe_ctrl_divfsm
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = DEFAULT_DIV_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  bit_t start,
  input  bit_t dmem_busy,
  input  bit_t abort,
  output bit_t busy,
  output bit_t done
);

  localparam int            CW   = $clog2(DIV_CYCLES);
  localparam logic [CW-1:0] LOAD = CW'(DIV_CYCLES - 2);

  div_state_t    state, state_next;
  logic [CW-1:0] count, count_next;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DIV_IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // NOTE: every variable gets a default at the top of always_comb so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      DIV_IDLE: begin
        if (start && !dmem_busy) begin
          count_next = LOAD;
          state_next = (LOAD == '0) ? DIV_DONE : DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        count_next = count - CW'(1);
        if (count_next == '0) state_next = DIV_DONE;
      end
      DIV_DONE: state_next = DIV_IDLE;
      default:  state_next = DIV_IDLE;
    endcase
    // A trap flushes the divide in EX, whatever the divider was doing.
    if (abort) begin
      state_next = DIV_IDLE;
      count_next = '0;
    end
  end

  assign busy = ((state == DIV_IDLE) && start) || (state == DIV_BUSY);
  assign done = (state == DIV_DONE);

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller for the five-stage pipeline.
// Define CPU_MULTICYCLE_DIV_EN to enable the multi-cycle divider stall.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = DEFAULT_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_busy,
  input  logic        dmem_busy,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_gpr_waddr,
  input  logic        ex_div_start,
  input  logic        ex_branch,
  input  logic [31:0] ex_branch_target,
  input  logic        mem_trap,
  input  logic [31:0] mem_trap_pc,
  output logic        stall_if,
  output logic        stall_id,
  output logic        stall_ex,
  output logic        stall_mem,
  output logic        branch_flag,
  output logic        trap,
  output logic [31:0] redirect_pc,
  output logic        div_busy,
  output logic        div_done
);

  if (DIV_CYCLES < 2) begin : g_div_cycles_check
    $error("pipe_ctrl: DIV_CYCLES must be at least 2");
  end

  bit_t      load_use;
  bit_t      trap_avail, br_avail;
  word_t     trap_pc, br_pc;
  redirect_t pend_q, pend_d;

`ifdef CPU_MULTICYCLE_DIV_EN
  pipe_ctrl_divfsm #(.DIV_CYCLES(DIV_CYCLES)) u_divfsm (
    .clk       (clk),
    .rst       (rst),
    .start     (ex_div_start),
    .dmem_busy (dmem_busy),
    .abort     (trap),
    .busy      (div_busy),
    .done      (div_done)
  );
`else
  assign div_busy = 1'b0;
  assign div_done = ex_div_start && !rst;
`endif

  assign load_use = ex_is_load && (ex_gpr_waddr != '0) &&
                    ((id_use_rs && (id_rs == ex_gpr_waddr)) ||
                     (id_use_rt && (id_rt == ex_gpr_waddr)));

  assign stall_mem = dmem_busy;
  assign stall_ex  = stall_mem || div_busy;
  assign stall_id  = stall_ex || load_use;
  assign stall_if  = stall_id || imem_busy;

  // A live request is newer than anything pending, so it supplies the pc.
  assign trap_avail = mem_trap || (pend_q.kind == RD_TRAP);
  assign trap_pc    = mem_trap ? mem_trap_pc : pend_q.pc;
  assign br_avail   = ex_branch || (pend_q.kind == RD_BRANCH);
  assign br_pc      = ex_branch ? ex_branch_target : pend_q.pc;

  // A trap flushes EX, so only a MEM wait (not the divider) can hold it back.
  always_comb begin
    trap        = !rst && trap_avail && !dmem_busy;
    branch_flag = !rst && br_avail && !trap_avail && !stall_ex;
    redirect_pc = '0;
    if (trap)             redirect_pc = trap_pc;
    else if (branch_flag) redirect_pc = br_pc;
  end

  always_comb begin
    pend_d = pend_q;
    if (trap || branch_flag) begin
      pend_d = '{kind: RD_NONE, pc: '0};
    end else if (mem_trap) begin
      pend_d = '{kind: RD_TRAP, pc: mem_trap_pc};
    end else if (ex_branch && (pend_q.kind != RD_TRAP)) begin
      pend_d = '{kind: RD_BRANCH, pc: ex_branch_target};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= '{kind: RD_NONE, pc: '0};
    else     pend_q <= pend_d;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (DIV_CYCLES=32).
// Divider scenarios follow CPU_MULTICYCLE_DIV_EN as the RTL does.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_busy, dmem_busy;
  logic [4:0]  id_rs, id_rt;
  logic        id_use_rs, id_use_rt;
  logic        ex_is_load;
  logic [4:0]  ex_gpr_waddr;
  logic        ex_div_start;
  logic        ex_branch;
  logic [31:0] ex_branch_target;
  logic        mem_trap;
  logic [31:0] mem_trap_pc;
  logic        stall_if, stall_id, stall_ex, stall_mem;
  logic        branch_flag, trap;
  logic [31:0] redirect_pc;
  logic        div_busy, div_done;

  int checks   = 0;
  int failures = 0;

  pipe_ctrl #(.DIV_CYCLES(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .imem_busy        (imem_busy),
    .dmem_busy        (dmem_busy),
    .id_rs            (id_rs),
    .id_rt            (id_rt),
    .id_use_rs        (id_use_rs),
    .id_use_rt        (id_use_rt),
    .ex_is_load       (ex_is_load),
    .ex_gpr_waddr     (ex_gpr_waddr),
    .ex_div_start     (ex_div_start),
    .ex_branch        (ex_branch),
    .ex_branch_target (ex_branch_target),
    .mem_trap         (mem_trap),
    .mem_trap_pc      (mem_trap_pc),
    .stall_if         (stall_if),
    .stall_id         (stall_id),
    .stall_ex         (stall_ex),
    .stall_mem        (stall_mem),
    .branch_flag      (branch_flag),
    .trap             (trap),
    .redirect_pc      (redirect_pc),
    .div_busy         (div_busy),
    .div_done         (div_done)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    imem_busy = 0; dmem_busy = 0; id_rs = 0; id_rt = 0;
    id_use_rs = 0; id_use_rt = 0; ex_is_load = 0; ex_gpr_waddr = 0;
    ex_div_start = 0; ex_branch = 0; ex_branch_target = 0;
    mem_trap = 0; mem_trap_pc = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    #2;
    checks++;
    if ({trap, branch_flag, div_done, div_busy} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0000", {trap, branch_flag, div_done, div_busy});
    end
    checks++;
    if (redirect_pc !== 32'h0) begin
      failures++;
      $display("FAIL reset_redirect got=%h exp=00000000", redirect_pc);
    end
    dmem_busy = 1'b1;
    #1;
    checks++;
    if ({stall_if, stall_id, stall_ex, stall_mem} !== 4'b1111) begin
      failures++;
      $display("FAIL reset_stall_follow got=%b exp=1111", {stall_if, stall_id, stall_ex, stall_mem});
    end
    dmem_busy = 1'b0;
    ex_div_start = 1'b1;
    #1;
    checks++;
`ifdef CPU_MULTICYCLE_DIV_EN
    if ({div_busy, div_done} !== 2'b10) begin
      failures++;
      $display("FAIL reset_div_start got=%b exp=10", {div_busy, div_done});
    end
`else
    if ({div_busy, div_done} !== 2'b00) begin
      failures++;
      $display("FAIL reset_div_start got=%b exp=00", {div_busy, div_done});
    end
`endif
    clear_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({trap, branch_flag, div_done, div_busy, redirect_pc} !== 36'h0) begin
      failures++;
      $display("FAIL reset_release got=%h exp=0", {trap, branch_flag, div_done, div_busy, redirect_pc});
    end
    tick();
  endtask

  task automatic test_load_use();
    // {is_load, waddr, rs, rt, use_rs, use_rt, expected load_use}
    logic [18:0] vec [8];
    logic        exp;
    vec[0] = {1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1};
    vec[1] = {1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0};
    vec[2] = {1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b1, 1'b1};
    vec[3] = {1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0};
    vec[4] = {1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0};
    vec[5] = {1'b1, 5'd9, 5'd9, 5'd9, 1'b0, 1'b0, 1'b0};
    vec[6] = {1'b1, 5'd31, 5'd31, 5'd2, 1'b1, 1'b1, 1'b1};
    vec[7] = {1'b1, 5'd4, 5'd5, 5'd6, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      {ex_is_load, ex_gpr_waddr, id_rs, id_rt, id_use_rs, id_use_rt, exp} = vec[i];
      #1;
      checks++;
      if ({stall_if, stall_id, stall_ex, stall_mem} !== (exp ? 4'b1100 : 4'b0000)) begin
        failures++;
        $display("FAIL load_use[%0d] got=%b exp=%b", i,
                 {stall_if, stall_id, stall_ex, stall_mem}, exp ? 4'b1100 : 4'b0000);
      end
    end
    clear_inputs();
    imem_busy = 1'b1;
    #1;
    checks++;
    if ({stall_if, stall_id, stall_ex, stall_mem} !== 4'b1000) begin
      failures++;
      $display("FAIL imem_stall got=%b exp=1000", {stall_if, stall_id, stall_ex, stall_mem});
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_branch_live();
    ex_branch = 1'b1;
    ex_branch_target = 32'h1234_5678;
    #1;
    checks++;
    if ({trap, branch_flag, redirect_pc} !== {2'b01, 32'h1234_5678}) begin
      failures++;
      $display("FAIL branch_live got=%b/%h exp=01/12345678", {trap, branch_flag}, redirect_pc);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if ({trap, branch_flag, redirect_pc} !== 34'h0) begin
      failures++;
      $display("FAIL branch_live_after got=%b/%h exp=00/00000000", {trap, branch_flag}, redirect_pc);
    end
    tick();
  endtask

  task automatic test_branch_under_stall();
    logic [33:0] exp;
    for (int c = 0; c < 5; c++) begin
      dmem_busy = (c < 3);
      ex_branch = (c == 1);
      ex_branch_target = (c == 1) ? 32'h8000_0040 : 32'h0;
      #1;
      exp = (c == 3) ? {2'b01, 32'h8000_0040} : 34'h0;
      checks++;
      if ({trap, branch_flag, redirect_pc} !== exp) begin
        failures++;
        $display("FAIL branch_stall[c%0d] got=%h exp=%h", c, {trap, branch_flag, redirect_pc}, exp);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_trap_over_branch();
    logic [33:0] exp;
    for (int c = 0; c < 5; c++) begin
      dmem_busy = (c < 3);
      ex_branch = (c == 1);
      ex_branch_target = 32'h8000_0040;
      mem_trap = (c == 2);
      mem_trap_pc = 32'hBFC0_0380;
      #1;
      exp = (c == 3) ? {2'b10, 32'hBFC0_0380} : 34'h0;
      checks++;
      if ({trap, branch_flag, redirect_pc} !== exp) begin
        failures++;
        $display("FAIL trap_over_branch[c%0d] got=%h exp=%h", c, {trap, branch_flag, redirect_pc}, exp);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_trap_not_overwritten();
    logic [33:0] exp;
    for (int c = 0; c < 4; c++) begin
      dmem_busy = (c < 2);
      mem_trap = (c == 0);
      mem_trap_pc = 32'hBFC0_0200;
      ex_branch = (c == 1);
      ex_branch_target = 32'h8000_0100;
      #1;
      exp = (c == 2) ? {2'b10, 32'hBFC0_0200} : 34'h0;
      checks++;
      if ({trap, branch_flag, redirect_pc} !== exp) begin
        failures++;
        $display("FAIL trap_kept[c%0d] got=%h exp=%h", c, {trap, branch_flag, redirect_pc}, exp);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_newer_branch();
    logic [33:0] exp;
    for (int c = 0; c < 4; c++) begin
      dmem_busy = (c < 2);
      ex_branch = (c < 2);
      ex_branch_target = (c == 0) ? 32'h0000_0100 : 32'h0000_0200;
      #1;
      exp = (c == 2) ? {2'b01, 32'h0000_0200} : 34'h0;
      checks++;
      if ({trap, branch_flag, redirect_pc} !== exp) begin
        failures++;
        $display("FAIL newer_branch[c%0d] got=%h exp=%h", c, {trap, branch_flag, redirect_pc}, exp);
      end
      tick();
    end
    clear_inputs();
  endtask

`ifdef CPU_MULTICYCLE_DIV_EN
  task automatic test_divide(input bit with_dmem);
    logic [2:0] exp;
    for (int c = 0; c <= 32; c++) begin
      ex_div_start = (c <= 31);
      dmem_busy = with_dmem && (c == 5 || c == 6 || c == 7 || c == 31);
      #1;
      // {stall_ex, div_busy, div_done}
      exp = {(c <= 30) || dmem_busy, c <= 30, c == 31};
      checks++;
      if ({stall_ex, div_busy, div_done} !== exp) begin
        failures++;
        $display("FAIL divide%0d[c%0d] got=%b exp=%b", with_dmem, c,
                 {stall_ex, div_busy, div_done}, exp);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_trap_abort_div();
    logic [35:0] exp;
    for (int c = 0; c <= 34; c++) begin
      ex_div_start = (c <= 21);
      mem_trap = (c == 21);
      mem_trap_pc = 32'hBFC0_0380;
      #1;
      // {trap, div_busy, div_done, stall_ex, redirect_pc}
      exp = (c == 21) ? {4'b1101, 32'hBFC0_0380} :
            (c < 21)  ? {4'b0101, 32'h0} : 36'h0;
      checks++;
      if ({trap, div_busy, div_done, stall_ex, redirect_pc} !== exp) begin
        failures++;
        $display("FAIL trap_abort_div[c%0d] got=%h exp=%h", c,
                 {trap, div_busy, div_done, stall_ex, redirect_pc}, exp);
      end
      tick();
    end
    clear_inputs();
  endtask
`else
  task automatic test_divide_single();
    ex_div_start = 1'b1;
    #1;
    checks++;
    if ({stall_ex, div_busy, div_done} !== 3'b001) begin
      failures++;
      $display("FAIL divide_single got=%b exp=001", {stall_ex, div_busy, div_done});
    end
    tick();
    ex_div_start = 1'b0;
    #1;
    checks++;
    if ({stall_ex, div_busy, div_done} !== 3'b000) begin
      failures++;
      $display("FAIL divide_single_after got=%b exp=000", {stall_ex, div_busy, div_done});
    end
    tick();
  endtask
`endif

  task automatic test_async_reset();
    for (int c = 0; c < 5; c++) begin
`ifdef CPU_MULTICYCLE_DIV_EN
      ex_div_start = 1'b1;
`endif
      dmem_busy = (c >= 2);
      ex_branch = (c == 2);
      ex_branch_target = 32'h8000_0040;
      #1;
      checks++;
      if ({trap, branch_flag} !== 2'b00) begin
        failures++;
        $display("FAIL areset_pre[c%0d] got=%b exp=00", c, {trap, branch_flag});
      end
      tick();
    end
    ex_div_start = 1'b0;
    ex_branch = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({trap, branch_flag, div_done, div_busy, redirect_pc} !== 36'h0) begin
      failures++;
      $display("FAIL areset_outputs got=%h exp=0", {trap, branch_flag, div_done, div_busy, redirect_pc});
    end
    checks++;
    if ({stall_if, stall_id, stall_ex, stall_mem} !== 4'b1111) begin
      failures++;
      $display("FAIL areset_stalls got=%b exp=1111", {stall_if, stall_id, stall_ex, stall_mem});
    end
    tick();
    rst = 1'b0;
    clear_inputs();
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({trap, branch_flag, div_done, div_busy, stall_ex, redirect_pc} !== 37'h0) begin
        failures++;
        $display("FAIL areset_after[c%0d] got=%h exp=0", c,
                 {trap, branch_flag, div_done, div_busy, stall_ex, redirect_pc});
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_live();
    test_branch_under_stall();
    test_trap_over_branch();
    test_trap_not_overwritten();
    test_newer_branch();
`ifdef CPU_MULTICYCLE_DIV_EN
    test_divide(1'b0);
    test_divide(1'b1);
    test_trap_abort_div();
`else
    test_divide_single();
`endif
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
